// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream link: one beat of tdata/tlast qualified by tvalid/tready.
// Ports (through modports):
//   master : drives tdata, tvalid, tlast; samples tready
//   slave  : samples tdata, tvalid, tlast; drives tready
interface axis_pkt_fifo_if #(
   parameter int unsigned DW = 8
);
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tlast;
   logic          tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO. Beats are written speculatively
// and only become visible to the read side once the packet's tlast commits.
// Packets that overflow storage (or fail the optional length filter) are
// rolled back and counted as drops; the input side never back-pressures.
//
// Optional feature macro: AXIS_PKT_LEN_CHECK_EN enables min/max length
// filtering from packet_config; without it packet_config is ignored.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   s_axis         input stream (slave modport), tready = !rst
//   m_axis         output stream (master modport), only committed packets
//   packet_config  {max_len, min_len} in beats, 0 disables each bound
//   full           speculative + committed occupancy equals depth
//   empty          nothing committed in storage or output stage
//   pkt_count      committed packets not yet fully emitted
//   drop_count     saturating count of dropped packets
//   drop_pulse     one-cycle strobe per dropped packet
module axis_pkt_fifo #(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = 8
) (
   input  logic             clk,
   input  logic             rst,
   axis_pkt_fifo_if.slave   s_axis,
   axis_pkt_fifo_if.master  m_axis,
   input  logic [2*DW-1:0]  packet_config,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      pkt_count,
   output logic [15:0]      drop_count,
   output logic             drop_pulse
);
   localparam int unsigned DEPTH = 2**AW;
   localparam int unsigned PW    = AW + 1;

   typedef enum logic {ACCEPT, DROP} wr_state_t;

   wr_state_t     state;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] wr_commit;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] bcnt;

   logic [DW:0]   mem [DEPTH];
   logic [DW:0]   ram_q;
   logic          rd_vld;

   // Two-entry output stage; slot 0 drives the m_axis outputs.
   logic [DW-1:0] st_data [2];
   logic          st_last [2];
   logic [1:0]    st_cnt;
   logic          m_valid;

   logic          acc;
   logic          ovf;
   logic          too_long;
   logic          too_short;
   logic          drop;
   logic          wr_en;
   logic          commit;
   logic          pop;
   logic          pop_last;
   logic          rd_en;
   logic          push_idx;
   logic [PW-1:0] occ;
   logic [PW-1:0] cur_cnt;
   logic [PW-1:0] wr_ptr_n;
   logic [PW-1:0] wr_commit_n;
   logic [PW-1:0] rd_ptr_n;
   logic [1:0]    st_cnt_n;

   assign s_axis.tready = !rst;
   assign m_axis.tdata  = st_data[0];
   assign m_axis.tlast  = st_last[0];
   assign m_axis.tvalid = m_valid;

   assign acc     = s_axis.tvalid && s_axis.tready;
   // Beats of the current packet including the one being presented.
   assign cur_cnt = (bcnt == '1) ? bcnt : bcnt + PW'(1);

`ifdef AXIS_PKT_LEN_CHECK_EN
   localparam int unsigned CW = (PW > DW) ? PW : DW;
   logic [DW-1:0] min_len;
   logic [DW-1:0] max_len;
   assign min_len   = packet_config[DW-1:0];
   assign max_len   = packet_config[2*DW-1:DW];
   assign too_long  = (max_len != '0) && (CW'(cur_cnt) > CW'(max_len));
   assign too_short = s_axis.tlast && (CW'(cur_cnt) < CW'(min_len));
`else
   logic unused_cfg;
   assign unused_cfg = ^packet_config;
   assign too_long   = 1'b0;
   assign too_short  = 1'b0;
`endif

   // Write decisions, read issue and next pointer values.
   always_comb begin
      occ         = wr_ptr - rd_ptr;
      ovf         = (occ == PW'(DEPTH));
      drop        = 1'b0;
      wr_en       = 1'b0;
      commit      = 1'b0;
      if (acc && (state == ACCEPT)) begin
         drop   = ovf || too_long || too_short;
         wr_en  = !drop;
         commit = wr_en && s_axis.tlast;
      end

      pop      = m_valid && m_axis.tready;
      pop_last = pop && st_last[0];
      // Stage fill after this cycle's push/pop; a new read may only be
      // issued if its data will still find a free slot next cycle.
      st_cnt_n = st_cnt + 2'(rd_vld) - 2'(pop);
      rd_en    = (rd_ptr != wr_commit) && (st_cnt_n <= 2'd1);
      push_idx = (st_cnt == 2'd2) || ((st_cnt == 2'd1) && !pop);

      wr_ptr_n = wr_ptr;
      if (wr_en) wr_ptr_n = wr_ptr + PW'(1);
      if (drop)  wr_ptr_n = wr_commit;
      wr_commit_n = commit ? (wr_ptr + PW'(1)) : wr_commit;
      rd_ptr_n    = rd_en ? (rd_ptr + PW'(1)) : rd_ptr;
   end

   // Storage RAM with synchronous read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
      if (rd_en) ram_q <= mem[rd_ptr[AW-1:0]];
   end

   // Pointers, write FSM, counters, flags and output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ACCEPT;
         wr_ptr     <= '0;
         wr_commit  <= '0;
         rd_ptr     <= '0;
         bcnt       <= '0;
         rd_vld     <= 1'b0;
         st_cnt     <= '0;
         m_valid    <= 1'b0;
         st_data[0] <= '0;
         st_data[1] <= '0;
         st_last[0] <= 1'b0;
         st_last[1] <= 1'b0;
         full       <= 1'b0;
         empty      <= 1'b1;
         pkt_count  <= '0;
         drop_count <= '0;
         drop_pulse <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_n;
         wr_commit  <= wr_commit_n;
         rd_ptr     <= rd_ptr_n;
         rd_vld     <= rd_en;
         full       <= ((wr_ptr_n - rd_ptr_n) == PW'(DEPTH));
         // A read in flight counts as output-stage content.
         empty      <= (rd_ptr_n == wr_commit_n) && (st_cnt_n == 2'd0) && !rd_en;
         drop_pulse <= drop;
         if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
         pkt_count  <= pkt_count + PW'(commit) - PW'(pop_last);

         if (state == ACCEPT) begin
            if (acc) begin
               if (s_axis.tlast) begin
                  bcnt <= '0;
               end else if (drop) begin
                  bcnt  <= '0;
                  state <= DROP;
               end else begin
                  bcnt <= cur_cnt;
               end
            end
         end else begin
            if (acc && s_axis.tlast) begin
               bcnt  <= '0;
               state <= ACCEPT;
            end
         end

         st_cnt  <= st_cnt_n;
         m_valid <= (st_cnt_n != 2'd0);
         if (pop) begin
            st_data[0] <= st_data[1];
            st_last[0] <= st_last[1];
         end
         // Push lands after the shift so it wins when both target slot 0.
         if (rd_vld) begin
            st_data[push_idx] <= ram_q[DW-1:0];
            st_last[push_idx] <= ram_q[DW];
         end
      end
   end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo (AW=4, DW=8): table of packets plus
// hand-written sequences for reset, latency, backpressure and length filter.
module tb_axis_pkt_fifo;
   logic        clk;
   logic        rst;
   logic [15:0] cfg;
   logic        full;
   logic        empty;
   logic [4:0]  pkt_count;
   logic [15:0] drop_count;
   logic        drop_pulse;

   axis_pkt_fifo_if #(.DW(8)) s_if ();
   axis_pkt_fifo_if #(.DW(8)) m_if ();

   axis_pkt_fifo #(.AW(4), .DW(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis        (s_if),
      .m_axis        (m_if),
      .packet_config (cfg),
      .full          (full),
      .empty         (empty),
      .pkt_count     (pkt_count),
      .drop_count    (drop_count),
      .drop_pulse    (drop_pulse)
   );

   typedef struct {
      int         len;
      logic [7:0] base;
      int         mode;       // 0: ready low while sending, 1: high, 2: toggle
      bit         drop;
      bit         exp_full;   // full right after the last beat
      int         exp_drops;  // cumulative drop_count afterwards
   } vec_t;

   int         checks;
   int         errors;
   int         rdy_mode;
   int         pulse_cnt;
   int         pulse_base;
   int         peak;
   int         exp_drops;
   logic [8:0] sb [$];
   vec_t       vec [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_pkt(input int len, input logic [7:0] base, input bit deliver);
      for (int i = 0; i < len; i++) begin
         s_if.tdata  = base + 8'(i);
         s_if.tvalid = 1'b1;
         s_if.tlast  = (i == len - 1);
         if (deliver) sb.push_back({s_if.tlast, s_if.tdata});
         step(1);
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || m_if.tvalid) && n < 400) begin
         step(1);
         n++;
      end
      check("drain_done", 32'(n < 400), 32'd1);
      step(2);
      check("empty_after_drain", 32'(empty), 32'd1);
      check("pkts_after_drain", 32'(pkt_count), 32'd0);
   endtask

   task automatic check_reset_vals();
      check("rst_s_tready", 32'(s_if.tready), 32'd0);
      check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
      check("rst_m_tdata", 32'(m_if.tdata), 32'd0);
      check("rst_m_tlast", 32'(m_if.tlast), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_pkt_count", 32'(pkt_count), 32'd0);
      check("rst_drop_count", 32'(drop_count), 32'd0);
      check("rst_drop_pulse", 32'(drop_pulse), 32'd0);
   endtask

   // Downstream ready pattern, updated away from the input drive time.
   initial begin
      m_if.tready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rdy_mode == 0)      m_if.tready = 1'b0;
         else if (rdy_mode == 1) m_if.tready = 1'b1;
         else                    m_if.tready = ~m_if.tready;
      end
   end

   // Output monitor: scoreboard compare, stall stability, pulse/peak tracking.
   initial begin
      logic       stall_prev;
      logic [8:0] prev_beat;
      logic [8:0] exp_beat;
      stall_prev = 1'b0;
      prev_beat  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (drop_pulse) pulse_cnt++;
            if (32'(pkt_count) > peak) peak = 32'(pkt_count);
            if (stall_prev) begin
               check("hold_valid", 32'(m_if.tvalid), 32'd1);
               check("hold_beat", 32'({m_if.tlast, m_if.tdata}), 32'(prev_beat));
            end
            if (m_if.tvalid && m_if.tready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat actual=%0h required=none", {m_if.tlast, m_if.tdata});
               end else begin
                  exp_beat = sb.pop_front();
                  check("out_beat", 32'({m_if.tlast, m_if.tdata}), 32'(exp_beat));
               end
            end
            stall_prev = m_if.tvalid && !m_if.tready;
            prev_beat  = {m_if.tlast, m_if.tdata};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      pulse_cnt = 0;
      peak      = 0;
      exp_drops = 0;
      cfg       = '0;
      rdy_mode  = 1;

      vec[0] = '{len: 4,  base: 8'h11, mode: 1, drop: 1'b0, exp_full: 1'b0, exp_drops: 0};
      vec[1] = '{len: 1,  base: 8'h30, mode: 1, drop: 1'b0, exp_full: 1'b0, exp_drops: 0};
      vec[2] = '{len: 16, base: 8'h40, mode: 0, drop: 1'b0, exp_full: 1'b1, exp_drops: 0};
      vec[3] = '{len: 17, base: 8'h60, mode: 0, drop: 1'b1, exp_full: 1'b0, exp_drops: 1};
      vec[4] = '{len: 20, base: 8'h80, mode: 0, drop: 1'b1, exp_full: 1'b0, exp_drops: 2};
      vec[5] = '{len: 3,  base: 8'hA0, mode: 0, drop: 1'b0, exp_full: 1'b0, exp_drops: 2};
      vec[6] = '{len: 5,  base: 8'hC0, mode: 2, drop: 1'b0, exp_full: 1'b0, exp_drops: 2};
      vec[7] = '{len: 15, base: 8'h01, mode: 0, drop: 1'b0, exp_full: 1'b0, exp_drops: 2};

      // Reset held 3 cycles with input traffic present.
      rst         = 1'b1;
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'h77;
      s_if.tlast  = 1'b1;
      step(3);
      check_reset_vals();
      rst         = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      step(1);
      check("post_rst_s_tready", 32'(s_if.tready), 32'd1);
      check("post_rst_empty", 32'(empty), 32'd1);

      // Single packet latency and back-to-back delivery.
      rdy_mode = 1;
      send_pkt(4, 8'h11, 1'b1);
      check("lat_e0_valid", 32'(m_if.tvalid), 32'd0);
      check("lat_e0_pkts", 32'(pkt_count), 32'd1);
      step(1);
      check("lat_e1_valid", 32'(m_if.tvalid), 32'd0);
      step(1);
      check("lat_e2_valid", 32'(m_if.tvalid), 32'd1);
      check("lat_e2_data", 32'(m_if.tdata), 32'h11);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("b2b_valid", 32'(m_if.tvalid), 32'd1);
      end
      drain();

      // Packet table.
      for (int k = 0; k < 8; k++) begin
         rdy_mode   = vec[k].mode;
         pulse_base = pulse_cnt;
         send_pkt(vec[k].len, vec[k].base, !vec[k].drop);
         check("vec_full", 32'(full), 32'(vec[k].exp_full));
         if (vec[k].mode == 0) begin
            step(3);
            check("vec_pkts_held", 32'(pkt_count), 32'(!vec[k].drop));
            check("vec_empty_held", 32'(empty), 32'(vec[k].drop));
            rdy_mode = 1;
         end
         drain();
         exp_drops = vec[k].exp_drops;
         check("vec_drop_count", 32'(drop_count), 32'(exp_drops));
         check("vec_drop_pulses", 32'(pulse_cnt - pulse_base), 32'(vec[k].drop));
      end

      // Backpressure: two packets with toggling ready.
      rdy_mode = 2;
      peak     = 0;
      send_pkt(5, 8'h51, 1'b1);
      send_pkt(5, 8'h61, 1'b1);
      drain();
      check("bp_peak_pkts", 32'(peak), 32'd2);
      rdy_mode = 1;

`ifdef AXIS_PKT_LEN_CHECK_EN
      // Length filter: only the 3-beat packet fits min 2 / max 4.
      cfg        = {8'd4, 8'd2};
      pulse_base = pulse_cnt;
      send_pkt(1, 8'h21, 1'b0);
      step(2);
      send_pkt(3, 8'h31, 1'b1);
      step(2);
      send_pkt(6, 8'h41, 1'b0);
      drain();
      exp_drops = exp_drops + 2;
      check("len_drop_count", 32'(drop_count), 32'(exp_drops));
      check("len_drop_pulses", 32'(pulse_cnt - pulse_base), 32'd2);
      cfg = '0;
`endif

      // Reset in the middle of a packet.
      rdy_mode = 1;
      for (int i = 0; i < 2; i++) begin
         s_if.tdata  = 8'h90 + 8'(i);
         s_if.tvalid = 1'b1;
         s_if.tlast  = 1'b0;
         step(1);
      end
      s_if.tvalid = 1'b0;
      rst         = 1'b1;
      step(3);
      check_reset_vals();
      rst = 1'b0;
      step(1);
      send_pkt(2, 8'hE0, 1'b1);
      drain();
      check("mid_rst_drop_count", 32'(drop_count), 32'd0);
      step(5);
      check("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
